memsave_stream: RTL and testbench

MEMSAVE_STREAM -- requirements
Module: memsave_stream

---
 rtl/memsave_stream.sv | 215 +++++++++++++++++++++
 tb/tb_memsave_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memsave_stream.sv
`default_nettype none
// ============================================================================
//  Module      : memsave_stream
//  Description : Streams WORD_COUNT words out of a synchronous-read memory
//                (1-cycle read latency) to a valid/ready flash writer. A
//                2-entry output buffer absorbs the read latency so that
//                back-to-back transfers run at one word per cycle.
//                Optional macro MEMSAVE_CHECKSUM_EN appends one extra word:
//                the modulo-2^32 sum of all streamed data words.
//  Revision    : 1.0 - initial release
// ============================================================================
module memsave_stream #(
  parameter int WORD_COUNT = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clock_sig,
  input  logic              reset_sig,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [31:0]       mem_q,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;

  // Read issued last cycle; its data arrives on mem_q this cycle.
  logic              in_flight;
  logic              in_flight_last;

  // Two-entry buffer: head drives the stream outputs, tail catches the
  // word that lands while the head is stalled.
  logic              head_valid;
  logic              head_last;
  logic [31:0]       head_data;
  logic              tail_valid;
  logic              tail_last;
  logic [31:0]       tail_data;

  logic              pop;
  logic              push;
  logic              issue;
  logic              issue_last;
  logic [1:0]        occupancy;
  logic [31:0]       push_data;

`ifdef MEMSAVE_CHECKSUM_EN
  logic [31:0]       sum_acc;
  // Every memory read has been issued; the next issue slot carries the sum.
  logic              data_issued;
  logic              in_flight_sum;

  assign issue_last = data_issued;
  assign push_data  = in_flight_sum ? sum_acc : mem_q;
`else
  assign issue_last = (rd_addr == LAST_ADDR);
  assign push_data  = mem_q;
`endif

  assign pop  = head_valid & out_ready;
  assign push = in_flight;

  // Occupancy after this edge's pop; counting the pop keeps full rate when
  // the sink is ready, while never letting more than two words be owed.
  assign occupancy = 2'(head_valid) + 2'(tail_valid) + 2'(in_flight) - 2'(pop);
  assign issue     = (state == RUN) && (occupancy < 2'd2);

  assign mem_rdaddress = rd_addr;
  assign out_data      = head_data;
  assign out_valid     = head_valid;
  assign out_last      = head_valid & head_last;

  // Control FSM, read address generator and output buffer.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_addr        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      head_valid     <= 1'b0;
      head_last      <= 1'b0;
      head_data      <= '0;
      tail_valid     <= 1'b0;
      tail_last      <= 1'b0;
      tail_data      <= '0;
`ifdef MEMSAVE_CHECKSUM_EN
      sum_acc        <= '0;
      data_issued    <= 1'b0;
      in_flight_sum  <= 1'b0;
`endif
    end else if (abort) begin
      // Abort wins over start and over any transfer; read data in flight
      // is dropped.
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_addr        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      head_valid     <= 1'b0;
      head_last      <= 1'b0;
      head_data      <= '0;
      tail_valid     <= 1'b0;
      tail_last      <= 1'b0;
      tail_data      <= '0;
`ifdef MEMSAVE_CHECKSUM_EN
      sum_acc        <= '0;
      data_issued    <= 1'b0;
      in_flight_sum  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_addr <= '0;
`ifdef MEMSAVE_CHECKSUM_EN
            sum_acc     <= '0;
            data_issued <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (issue) begin
            if (issue_last) begin
              state <= DRAIN;
            end
`ifdef MEMSAVE_CHECKSUM_EN
            if (!data_issued) begin
              if (rd_addr == LAST_ADDR) begin
                data_issued <= 1'b1;
              end else begin
                rd_addr <= rd_addr + ADDR_W'(1);
              end
            end
`else
            if (!issue_last) begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end
`endif
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rd_addr <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      in_flight      <= issue;
      in_flight_last <= issue & issue_last;
`ifdef MEMSAVE_CHECKSUM_EN
      in_flight_sum  <= issue & data_issued;
      if (push && !in_flight_sum) begin
        sum_acc <= sum_acc + mem_q;
      end
`endif

      // Head only changes on a pop, so a stalled word stays stable.
      if (push && pop) begin
        if (tail_valid) begin
          head_data <= tail_data;
          head_last <= tail_last;
          tail_data <= push_data;
          tail_last <= in_flight_last;
        end else begin
          head_data <= push_data;
          head_last <= in_flight_last;
        end
      end else if (push) begin
        if (head_valid) begin
          tail_valid <= 1'b1;
          tail_data  <= push_data;
          tail_last  <= in_flight_last;
        end else begin
          head_valid <= 1'b1;
          head_data  <= push_data;
          head_last  <= in_flight_last;
        end
      end else if (pop) begin
        head_valid <= tail_valid;
        head_data  <= tail_data;
        head_last  <= tail_last;
        tail_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memsave_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memsave_stream
//  Description : Scoreboard bench for memsave_stream. Three instances
//                (WORD_COUNT = 1024, 1, 4) with behavioural 1-cycle-latency
//                memories. Expectations follow MEMSAVE_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memsave_stream;

`ifdef MEMSAVE_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int N_BIG = 1024;
  localparam int NW0   = N_BIG + (CSUM ? 1 : 0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic abort_off = 1'b0;
  logic ready_on  = 1'b1;

  logic        start0, abort0, ready0, busy0, done0, valid0, last0;
  logic [9:0]  addr0;
  logic [31:0] q0, data0;
  logic        start1, busy1, done1, valid1, last1;
  logic [9:0]  addr1;
  logic [31:0] q1, data1;
  logic        start4, busy4, done4, valid4, last4;
  logic [9:0]  addr4;
  logic [31:0] q4, data4;

  memsave_stream #(.WORD_COUNT(1024), .ADDR_W(10)) dut (
    .clock_sig(clk), .reset_sig(rst), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .mem_rdaddress(addr0), .mem_q(q0),
    .out_data(data0), .out_valid(valid0), .out_ready(ready0), .out_last(last0));

  memsave_stream #(.WORD_COUNT(1), .ADDR_W(10)) dut1 (
    .clock_sig(clk), .reset_sig(rst), .start(start1), .abort(abort_off),
    .busy(busy1), .done(done1), .mem_rdaddress(addr1), .mem_q(q1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready_on), .out_last(last1));

  memsave_stream #(.WORD_COUNT(4), .ADDR_W(10)) dut4 (
    .clock_sig(clk), .reset_sig(rst), .start(start4), .abort(abort_off),
    .busy(busy4), .done(done4), .mem_rdaddress(addr4), .mem_q(q4),
    .out_data(data4), .out_valid(valid4), .out_ready(ready_on), .out_last(last4));

  // Memories with one cycle of read latency.
  logic [31:0] mem0 [N_BIG];
  logic [31:0] mem4 [4];
  always @(posedge clk) q0 <= mem0[addr0];
  always @(posedge clk) q1 <= (addr1 == 10'd0) ? 32'hDEADBEEF : 32'h0;
  always @(posedge clk) q4 <= (addr4 < 10'd4) ? mem4[addr4[1:0]] : 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {last, data} words per instance.
  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  logic [32:0] exp4[$];

  task automatic push_big(input int n, input bit full);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < n; i++) begin
      exp0.push_back({(full && (i == n - 1) && !CSUM), mem0[i]});
      s += mem0[i];
    end
    if (full && CSUM) exp0.push_back({1'b1, s});
  endtask

  // Monitor for the 1024-word instance: order, last flag, stall stability, done.
  logic        pend_done0 = 1'b0;
  logic        stall0     = 1'b0;
  logic [32:0] stall_word0;
  int          done_cnt0  = 0;
  int          xfer0      = 0;
  always @(negedge clk) begin
    logic [32:0] w;
    if (rst) begin
      pend_done0 = 1'b0;
      stall0     = 1'b0;
    end else begin
      if (pend_done0) begin
        check("done_pulse0", done0, 1);
        check("busy_fall0", busy0, 0);
        pend_done0 = 1'b0;
      end else if (done0) begin
        check("spurious_done0", done0, 0);
      end
      if (done0) done_cnt0++;
      if (stall0) begin
        check("stall_valid0", valid0, 1);
        check("stall_word0", {last0, data0}, stall_word0);
      end
      stall0      = valid0 && !ready0 && !abort0;
      stall_word0 = {last0, data0};
      if (valid0 && ready0 && !abort0) begin
        xfer0++;
        n_checks++;
        if (exp0.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word0: got 0x%0h expected no word", {last0, data0});
        end else begin
          w = exp0.pop_front();
          n_checks--;
          check("word0", {last0, data0}, w);
          if (w[32]) pend_done0 = 1'b1;
        end
      end
    end
  end

  // Monitors for the single-word and four-word instances.
  logic pend_done1 = 1'b0, pend_done4 = 1'b0;
  int   done_cnt1 = 0, done_cnt4 = 0, xfer4 = 0;
  always @(negedge clk) begin
    logic [32:0] w;
    if (!rst) begin
      if (pend_done1) begin
        check("done_pulse1", done1, 1);
        pend_done1 = 1'b0;
      end else if (done1) check("spurious_done1", done1, 0);
      if (done1) done_cnt1++;
      if (valid1) begin
        if (exp1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_word1: got 0x%0h expected no word", {last1, data1});
        end else begin
          w = exp1.pop_front();
          check("word1", {last1, data1}, w);
          if (w[32]) pend_done1 = 1'b1;
        end
      end
      if (pend_done4) begin
        check("done_pulse4", done4, 1);
        pend_done4 = 1'b0;
      end else if (done4) check("spurious_done4", done4, 0);
      if (done4) done_cnt4++;
      if (valid4) begin
        xfer4++;
        if (exp4.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_word4: got 0x%0h expected no word", {last4, data4});
        end else begin
          w = exp4.pop_front();
          check("word4", {last4, data4}, w);
          if (w[32]) pend_done4 = 1'b1;
        end
      end
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Directed stimulus.
  initial begin
    int bubbles;
    int base;
    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; start4 = 1'b0;
    for (int i = 0; i < N_BIG; i++) mem0[i] = 32'(i) * 32'h01010101;
    mem4[0] = 32'h1; mem4[1] = 32'h2; mem4[2] = 32'h3; mem4[3] = 32'hFFFFFFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", valid0, 0);
    check("rst_last", last0, 0);
    check("rst_data", data0, 0);
    check("rst_addr", addr0, 0);
    rst = 1'b0;
    tick;

    // Full save, sink always ready: latency, no bubbles, done.
    ready0 = 1'b1;
    push_big(N_BIG, 1'b1);
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    check("busy_after_start", busy0, 1);
    tick;
    check("lat_not_yet", valid0, 0);
    tick;
    check("lat_valid", valid0, 1);
    check("lat_data", data0, 0);
    bubbles = 0;
    for (int i = 0; i < NW0; i++) begin
      if (!valid0) bubbles++;
      tick;
    end
    check("A_bubbles", bubbles, 0);
    for (int k = 0; k < 20 && busy0; k++) tick;
    tick;
    check("A_done_count", done_cnt0, 1);
    check("A_queue_empty", exp0.size(), 0);
    check("A_addr_idle", addr0, 0);

    // Stalling sink 1,0,0,1 and an ignored start while busy.
    push_big(N_BIG, 1'b1);
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      ready0 = pat[c % 4];
      start0 = (c == 300);
      tick;
      if (!busy0) break;
    end
    start0 = 1'b0;
    ready0 = 1'b1;
    check("B_finished", busy0, 0);
    tick;
    tick;
    check("B_done_count", done_cnt0, 2);
    check("B_queue_empty", exp0.size(), 0);

    // Abort while the fifth word is stalled.
    push_big(4, 1'b0);
    base = xfer0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick;
      if (xfer0 - base >= 4) break;
    end
    ready0 = 1'b0;
    check("D_four_xfers", xfer0 - base, 4);
    check("D_word5_valid", valid0, 1);
    check("D_word5_data", data0, mem0[4]);
    abort0 = 1'b1;
    tick;
    abort0 = 1'b0;
    check("D_valid_cleared", valid0, 0);
    check("D_busy_cleared", busy0, 0);
    check("D_queue_empty", exp0.size(), 0);

    // Restart in the cycle after abort, then reset mid-stream.
    push_big(N_BIG, 1'b1);
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    ready0 = 1'b1;
    tick;
    tick;
    check("R_restart_valid", valid0, 1);
    check("R_restart_data", data0, mem0[0]);
    repeat (10) tick;
    rst = 1'b1;
    #1;
    check("R_rst_busy", busy0, 0);
    check("R_rst_valid", valid0, 0);
    check("R_rst_last", last0, 0);
    check("R_rst_data", data0, 0);
    check("R_rst_addr", addr0, 0);
    check("R_rst_done", done0, 0);
    tick;
    rst = 1'b0;
    exp0.delete();
    repeat (5) tick;
    check("R_idle_after_reset", busy0, 0);
    check("R_no_done", done_cnt0, 2);

    // Single-word save.
    if (CSUM) begin
      exp1.push_back({1'b0, 32'hDEADBEEF});
      exp1.push_back({1'b1, 32'hDEADBEEF});
    end else begin
      exp1.push_back({1'b1, 32'hDEADBEEF});
    end
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int k = 0; k < 20 && busy1; k++) tick;
    tick;
    check("C_finished", busy1, 0);
    check("C_done_count", done_cnt1, 1);
    check("C_queue_empty", exp1.size(), 0);

    // Four-word save {1,2,3,FFFFFFFF}; checksum word 5 when enabled.
    exp4.push_back({1'b0, 32'h1});
    exp4.push_back({1'b0, 32'h2});
    exp4.push_back({1'b0, 32'h3});
    exp4.push_back({!CSUM, 32'hFFFFFFFF});
    if (CSUM) exp4.push_back({1'b1, 32'h5});
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int k = 0; k < 30 && busy4; k++) tick;
    tick;
    check("E_finished", busy4, 0);
    check("E_word_count", xfer4, CSUM ? 5 : 4);
    check("E_done_count", done_cnt4, 1);
    check("E_queue_empty", exp4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
